regfile_stream_decoder: RTL and testbench
=========================================

Name: regfile_stream_decoder

Overview:
- Streaming successor to the flat register-bundle splitter.
- Accepts a trace register snapshot as a sequence of BEAT_WIDTH-bit beats over a valid/ready stream, assembles the full NUM_REGS*REG_WIDTH record, and presents it on a held, back-pressurable output.
- Detects framing errors and resynchronises on them.
- Sits between the trace input stream and the per-step decode/checker logic.
- Word order is unchanged: register 0 (eax) occupies the MSBs.

Parameters:
- REG_WIDTH, 32, width of one register.
- NUM_REGS, 10, registers per record.
- BEAT_WIDTH, 64, input beat width. NUM_REGS*REG_WIDTH must be an exact multiple of BEAT_WIDTH; a static check fails elaboration otherwise.
- Derived: REC_W = NUM_REGS*REG_WIDTH; BEATS = REC_W/BEAT_WIDTH (default 5). BEATS must be ≥ 2.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  decoder can accept a beat.
- in_data  in  BEAT_WIDTH  beat payload. The first beat of a record carries REC_W-1 down to REC_W-BEAT_WIDTH.
- in_last  in  1  marks the final beat of a record.
- out_valid  out  1  assembled record available.
- out_ready  in  1  consumer accepts the record.
- out_regs  out  REC_W  assembled record. Register i is at bits [REC_W-1-i*REG_WIDTH -: REG_WIDTH].
- err_framing  out  1  one-cycle pulse on a framing error.
- rec_count  out  32  number of records delivered (output handshakes).

Behaviour:
- Beat transfer: in_valid && in_ready at a rising edge. Record transfer: out_valid && out_ready at a rising edge.
- Reset (asynchronous assert, synchronous release):
  - out_valid=0, out_regs=0, err_framing=0, rec_count=0.
  - beat counter = 0, FSM = ASSEMBLE, shadow buffer = 0.
  - in_ready is 1 immediately after reset.
- FSM state ASSEMBLE (beat counter bc in 0..BEATS-1):
  - Accepted beat with bc < BEATS-1 and in_last=0: store the beat in the shadow slot for bc; bc++.
  - Accepted beat with bc < BEATS-1 and in_last=1 (early last): drop the partial record, pulse err_framing, set bc=0, stay in ASSEMBLE.
  - Accepted beat with bc = BEATS-1 and in_last=1: the record is complete. On the next edge, out_regs = {shadow slots 0..BEATS-2, in_data}, out_valid=1, bc=0.
  - Accepted beat with bc = BEATS-1 and in_last=0 (missing last): drop the record, pulse err_framing, set bc=0, go to DISCARD.
- FSM state DISCARD:
  - in_ready=1.
  - Beats are consumed and ignored.
  - An accepted beat with in_last=1 returns the FSM to ASSEMBLE with bc=0. No additional error pulse.
- in_ready in ASSEMBLE:
  - Equals 0 only when bc = BEATS-1 && out_valid && !out_ready. Otherwise it is 1.
  - So non-final beats keep streaming while the output is stalled (double buffering).
  - A final beat is accepted in the same cycle the held record drains; the new record replaces it next edge with out_valid staying 1.
- Latency: final beat accepted at edge N gives out_valid=1 and new out_regs visible after edge N. Sustained throughput is one record per BEATS cycles.
- Output hold: while out_valid && !out_ready, out_regs and out_valid are stable. out_valid drops after a record transfer unless a new record completes on the same edge.
- err_framing: high for exactly one cycle after the offending beat's edge. Errors never touch out_valid or out_regs.
- rec_count: increments by 1 on each record transfer; wraps from 2^32-1 to 0.
- Inputs are ignored when in_valid=0. in_data and in_last are don't-care then.
- Reset mid-record: the partial shadow data is discarded and the FSM returns to ASSEMBLE with bc=0. A held output record is lost (out_valid=0).

Test Plan:
- Default params: 5 beats carrying eax=0x11111111 … eflags=0x00000246 (eax first, eflags in the low 32 bits of beat 4), last on beat 4, out_ready=1 -> out_valid=1 the cycle after beat 4; out_regs[319:288]=0x11111111, out_regs[31:0]=0x00000246; rec_count=1.
- Two back-to-back records with out_ready=0 until cycle 20:
  - Beats 0-3 of record 2 are accepted while record 1 is held.
  - in_ready=0 on record 2's final beat.
  - When out_ready rises, record 1 transfers, record 2's final beat is accepted on the same edge, and out_regs shows record 2 next cycle.
  - rec_count steps 1 then 2.
- in_last on beat 2 -> err_framing single pulse, no out_valid; a following clean 5-beat record decodes correctly.
- 6-beat burst with in_last only on beat 5 -> err_framing pulse after beat 4, beat 5 discarded, no output; the next clean record decodes correctly.
- Assert rst_n=0 asynchronously after 3 beats while a record is held -> all outputs 0 immediately; a fresh 5-beat record after release decodes with rec_count=1.
- Param sweep REG_WIDTH=16, NUM_REGS=8, BEAT_WIDTH=32 (BEATS=4) -> register i appears at bits [127-16i -: 16]; random valid/ready toggling matches a reference model over 1000 records.

Source files
------------

// File: rtl/regfile_stream_decoder.sv
// Streaming register-record decoder: assembles BEATS input beats into one
// NUM_REGS*REG_WIDTH record, register 0 in the MSBs, with framing-error resync.
module regfile_stream_decoder #(
  parameter int REG_WIDTH  = 32,
  parameter int NUM_REGS   = 10,
  parameter int BEAT_WIDTH = 64
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [BEAT_WIDTH-1:0]           in_data,
  input  logic                            in_last,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [NUM_REGS*REG_WIDTH-1:0]   out_regs,
  output logic                            err_framing,
  output logic [31:0]                     rec_count
);

  localparam int REC_W = NUM_REGS * REG_WIDTH;
  localparam int BEATS = REC_W / BEAT_WIDTH;
  localparam int BC_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BC_W-1:0] LAST_BC = BC_W'(BEATS - 1);
  localparam logic [BC_W-1:0] BC_ONE  = BC_W'(1);

  generate
    if (((REC_W % BEAT_WIDTH) != 0) || (BEATS < 2)) begin : g_bad_params
      $error("regfile_stream_decoder: record width must be a multiple (>=2) of BEAT_WIDTH");
    end
  endgenerate

  typedef enum logic {
    ASSEMBLE = 1'b0,
    DISCARD  = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [BC_W-1:0]         bc_q, bc_d;
  logic [BEAT_WIDTH-1:0]   shadow_q [0:BEATS-2];
  logic [BEAT_WIDTH-1:0]   shadow_d [0:BEATS-2];
  logic                    out_valid_q, out_valid_d;
  logic [REC_W-1:0]        out_regs_q, out_regs_d;
  logic                    err_q, err_d;
  logic [31:0]             rec_count_q, rec_count_d;
  logic [REC_W-1:0]        rec_s;
  logic                    at_last_s;
  logic                    beat_fire_s;

  // The final beat may only enter when the held record is free or draining now.
  assign at_last_s   = (bc_q == LAST_BC);
  assign in_ready    = (state_q == DISCARD) || !(at_last_s && out_valid_q && !out_ready);
  assign beat_fire_s = in_valid && in_ready;

  assign out_valid   = out_valid_q;
  assign out_regs    = out_regs_q;
  assign err_framing = err_q;
  assign rec_count   = rec_count_q;

  // Full record as it would look if the current beat completes it.
  always_comb begin
    rec_s = '0;
    for (int i = 0; i < BEATS - 1; i++) begin
      rec_s[REC_W-1-i*BEAT_WIDTH -: BEAT_WIDTH] = shadow_q[i];
    end
    rec_s[BEAT_WIDTH-1:0] = in_data;
  end

  // Next-state logic for framing FSM, shadow buffer and output holding register.
  always_comb begin
    state_d     = state_q;
    bc_d        = bc_q;
    shadow_d    = shadow_q;
    out_valid_d = out_valid_q;
    out_regs_d  = out_regs_q;
    err_d       = 1'b0;
    rec_count_d = rec_count_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
      rec_count_d = rec_count_q + 32'd1;
    end else begin
      out_valid_d = out_valid_q;
    end

    case (state_q)
      ASSEMBLE: begin
        if (beat_fire_s) begin
          if (at_last_s) begin
            if (in_last) begin
              out_regs_d  = rec_s;
              out_valid_d = 1'b1;
              bc_d        = '0;
            end else begin
              err_d   = 1'b1;
              bc_d    = '0;
              state_d = DISCARD;
            end
          end else if (in_last) begin
            err_d = 1'b1;
            bc_d  = '0;
          end else begin
            for (int i = 0; i < BEATS - 1; i++) begin
              if (bc_q == BC_W'(i)) begin
                shadow_d[i] = in_data;
              end else begin
                shadow_d[i] = shadow_q[i];
              end
            end
            bc_d = bc_q + BC_ONE;
          end
        end else begin
          bc_d = bc_q;
        end
      end
      DISCARD: begin
        if (beat_fire_s && in_last) begin
          state_d = ASSEMBLE;
          bc_d    = '0;
        end else begin
          state_d = DISCARD;
        end
      end
      default: begin
        state_d = ASSEMBLE;
        bc_d    = '0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ASSEMBLE;
      bc_q        <= '0;
      out_valid_q <= 1'b0;
      out_regs_q  <= '0;
      err_q       <= 1'b0;
      rec_count_q <= 32'd0;
      for (int i = 0; i < BEATS - 1; i++) begin
        shadow_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      bc_q        <= bc_d;
      out_valid_q <= out_valid_d;
      out_regs_q  <= out_regs_d;
      err_q       <= err_d;
      rec_count_q <= rec_count_d;
      for (int i = 0; i < BEATS - 1; i++) begin
        shadow_q[i] <= shadow_d[i];
      end
    end
  end

endmodule

// File: tb/tb_regfile_stream_decoder.sv
// Bench for regfile_stream_decoder: directed table and sequences on the default
// configuration, randomized handshakes against a queue model on a 4-beat one.
module tb_regfile_stream_decoder;

  localparam int REC  = 320;
  localparam int REC2 = 128;
  localparam int BEATS2 = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic in_valid, in_ready, in_last, out_valid, out_ready, err_framing;
  logic [63:0] in_data;
  logic [REC-1:0] out_regs;
  logic [31:0] rec_count;

  logic in_valid2, in_ready2, in_last2, out_valid2, out_ready2, err_framing2;
  logic [31:0] in_data2;
  logic [REC2-1:0] out_regs2;
  logic [31:0] rec_count2;

  regfile_stream_decoder dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_regs(out_regs), .err_framing(err_framing),
    .rec_count(rec_count)
  );

  regfile_stream_decoder #(.REG_WIDTH(16), .NUM_REGS(8), .BEAT_WIDTH(32)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_data(in_data2), .in_last(in_last2), .out_valid(out_valid2),
    .out_ready(out_ready2), .out_regs(out_regs2), .err_framing(err_framing2),
    .rec_count(rec_count2)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [REC-1:0] act, input logic [REC-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor for the default instance: error pulses and delivered records.
  int err_seen = 0;
  int err_double = 0;
  logic [REC-1:0] got_q[$];
  initial begin
    logic err_prev;
    err_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (err_framing) err_seen++;
        if (err_framing && err_prev) err_double++;
        if (out_valid && out_ready) got_q.push_back(out_regs);
        err_prev = err_framing;
      end else begin
        err_prev = 1'b0;
      end
    end
  end

  // eax..reg8 step by 0x11111111 from base; eflags in the low word
  function automatic logic [REC-1:0] mk_rec(input logic [31:0] base, input logic [31:0] eflags);
    logic [REC-1:0] r;
    r = '0;
    for (int i = 0; i < 9; i++) r[REC-1-32*i -: 32] = base + 32'(i) * 32'h11111111;
    r[31:0] = eflags;
    return r;
  endfunction

  task automatic send1(input logic [63:0] d, input logic last);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    #1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, required 1", n);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    int          nbeats;
    int          last_at;
    int          exp_err;
    int          exp_rec;
    logic [31:0] base;
    logic [31:0] eflags;
  } vec_t;

  typedef struct {
    logic [31:0] d;
    logic        last;
  } beat_t;

  vec_t tbl[5];
  logic [REC-1:0] exp_r, exp_a, exp_b, exp_c, exp_d;
  logic [31:0] exp_cnt;

  // Reference model state for the 4-beat instance
  beat_t sq[$];
  int pend, cyc, kind, nb;
  logic disc, m_valid, m_err, m_ready;
  logic [REC2-1:0] acc, m_regs;
  logic [31:0] m_cnt;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{5, 4, 0, 1, 32'h11111111, 32'h00000246};
    tbl[1] = '{3, 2, 1, 0, 32'h01020304, 32'h00000000};
    tbl[2] = '{5, 4, 0, 1, 32'hA0B0C0D0, 32'h00000202};
    tbl[3] = '{6, 5, 1, 0, 32'h5A5A0000, 32'h00000001};
    tbl[4] = '{5, 4, 0, 1, 32'hDEAD0000, 32'h00000ACE};

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
    in_valid2 = 1'b0; in_data2 = '0; in_last2 = 1'b0; out_ready2 = 1'b0;
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_regs", out_regs, 0);
    check("rst_err", err_framing, 0);
    check("rst_count", rec_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 1);
    @(negedge clk);

    // Table: clean records, early last, missing last, each followed by recovery
    exp_cnt = 32'd0;
    for (int e = 0; e < 5; e++) begin
      exp_r = mk_rec(tbl[e].base, tbl[e].eflags);
      err_seen = 0;
      got_q.delete();
      for (int k = 0; k < tbl[e].nbeats; k++)
        send1((k < 5) ? exp_r[REC-1-64*k -: 64] : {tbl[e].base, 32'(k)}, k == tbl[e].last_at);
      check($sformatf("tbl%0d_latency", e), out_valid, tbl[e].exp_rec);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      check($sformatf("tbl%0d_err", e), err_seen, tbl[e].exp_err);
      check($sformatf("tbl%0d_nrec", e), got_q.size(), tbl[e].exp_rec);
      if (tbl[e].exp_rec != 0 && got_q.size() > 0) begin
        check($sformatf("tbl%0d_rec", e), got_q[0], exp_r);
        if (e == 0) begin
          check("tbl0_eax", got_q[0][319:288], 32'h11111111);
          check("tbl0_eflags", got_q[0][31:0], 32'h00000246);
        end
      end
      exp_cnt = exp_cnt + 32'(tbl[e].exp_rec);
      check($sformatf("tbl%0d_count", e), rec_count, exp_cnt);
    end

    // Back-to-back records against a stalled consumer
    exp_a = mk_rec(32'h10000000, 32'h0000000A);
    exp_b = mk_rec(32'h20000000, 32'h0000000B);
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) send1(exp_a[REC-1-64*k -: 64], k == 4);
    for (int k = 0; k < 4; k++) send1(exp_b[REC-1-64*k -: 64], 1'b0);
    in_valid = 1'b1; in_data = exp_b[63:0]; in_last = 1'b1;
    #1;
    check("bb_final_blocked", in_ready, 0);
    check("bb_held_valid", out_valid, 1);
    check("bb_held_regs", out_regs, exp_a);
    repeat (3) @(negedge clk);
    #1;
    check("bb_still_blocked", in_ready, 0);
    check("bb_still_held", out_regs, exp_a);
    check("bb_count_hold", rec_count, exp_cnt);
    out_ready = 1'b1;
    #1;
    check("bb_drain_ready", in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("bb_rec2_valid", out_valid, 1);
    check("bb_rec2_regs", out_regs, exp_b);
    check("bb_count1", rec_count, exp_cnt + 32'd1);
    @(negedge clk);
    check("bb_count2", rec_count, exp_cnt + 32'd2);
    check("bb_drained", out_valid, 0);

    // Asynchronous reset while a record is held and another is partial
    exp_c = mk_rec(32'h30000000, 32'h0000000C);
    exp_d = mk_rec(32'h40000000, 32'h0000000D);
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) send1(exp_c[REC-1-64*k -: 64], k == 4);
    for (int k = 0; k < 3; k++) send1(exp_a[REC-1-64*k -: 64], 1'b0);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_out_valid", out_valid, 0);
    check("ar_out_regs", out_regs, 0);
    check("ar_err", err_framing, 0);
    check("ar_count", rec_count, 0);
    check("ar_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    got_q.delete();
    for (int k = 0; k < 5; k++) send1(exp_d[REC-1-64*k -: 64], k == 4);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("ar_nrec", got_q.size(), 1);
    if (got_q.size() > 0) check("ar_rec", got_q[0], exp_d);
    check("ar_count1", rec_count, 1);
    check("err_single_cycle", err_double, 0);

    // Randomized valid/ready on the 4-beat instance vs. a queue-level model
    pend = 0; disc = 1'b0; m_valid = 1'b0; m_err = 1'b0; acc = '0; m_regs = '0;
    m_cnt = 32'd0; cyc = 0;
    while (m_cnt < 32'd1000 && cyc < 60000 && errors < 40) begin
      if (sq.size() == 0) begin
        kind = $urandom_range(0, 19);
        if (kind == 0) nb = $urandom_range(1, BEATS2 - 1);
        else if (kind == 1) nb = BEATS2 + 1 + $urandom_range(0, 2);
        else nb = BEATS2;
        for (int k = 0; k < nb; k++) sq.push_back('{$urandom, k == nb - 1});
      end
      in_valid2 = ($urandom_range(0, 3) != 0);
      if (in_valid2) begin
        in_data2 = sq[0].d;
        in_last2 = sq[0].last;
      end else begin
        in_data2 = $urandom;
        in_last2 = 1'($urandom_range(0, 1));
      end
      out_ready2 = ($urandom_range(0, 2) != 0);
      #1;
      m_ready = disc || !(pend == BEATS2 - 1 && m_valid && !out_ready2);
      check("rnd_out_valid", out_valid2, m_valid);
      if (m_valid) check("rnd_out_regs", out_regs2, m_regs);
      check("rnd_err", err_framing2, m_err);
      check("rnd_count", rec_count2, m_cnt);
      check("rnd_in_ready", in_ready2, m_ready);
      m_err = 1'b0;
      if (m_valid && out_ready2) begin
        m_cnt++;
        m_valid = 1'b0;
      end
      if (in_valid2 && m_ready) begin
        void'(sq.pop_front());
        if (disc) begin
          if (in_last2) disc = 1'b0;
        end else begin
          acc = (acc << 32) | REC2'(in_data2);
          pend++;
          if (in_last2) begin
            if (pend == BEATS2) begin
              m_valid = 1'b1;
              m_regs = acc;
            end else begin
              m_err = 1'b1;
            end
            pend = 0;
          end else if (pend == BEATS2) begin
            m_err = 1'b1;
            disc = 1'b1;
            pend = 0;
          end
        end
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    check("rnd_records_done", m_cnt, 1000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
